// File: rtl/baw_game_ctrl_if.sv
// Board-side inputs of the Black-and-White game controller:
// debounced button levels and card select switches.
interface baw_game_ctrl_if #(
  parameter int NUM_CARDS = 9
);
  logic                 btn_center;
  logic                 btn_top;
  logic                 btn_bottom;
  logic                 btn_left;
  logic                 btn_right;
  logic [NUM_CARDS-1:0] sw;

  modport master (
    output btn_center, btn_top, btn_bottom,
    output btn_left, btn_right, sw
  );

  modport slave (
    input btn_center, btn_top, btn_bottom,
    input btn_left, btn_right, sw
  );
endinterface

// File: rtl/baw_game_ctrl.sv
// Black-and-White game controller: turn order, move checks, scoring.
// Optional turn timeout auto-commit: define BAW_TURN_TIMEOUT_EN.
module baw_game_ctrl #(
  parameter int NUM_CARDS      = 9,
  parameter int VW             = $clog2(NUM_CARDS),
  parameter int RW             = $clog2(NUM_CARDS + 1),
  parameter int TIMEOUT_CYCLES = 100000000
) (
  input  logic                 clk,
  input  logic                 reset,
  baw_game_ctrl_if.slave       bus,
  output logic [2:0]           state,
  output logic [NUM_CARDS-1:0] p1_cards,
  output logic [NUM_CARDS-1:0] p2_cards,
  output logic [VW-1:0]        p1_hand,
  output logic [VW-1:0]        p2_hand,
  output logic                 p1_hand_black,
  output logic                 p2_hand_black,
  output logic [RW-1:0]        p1_black,
  output logic [RW-1:0]        p1_white,
  output logic [RW-1:0]        p2_black,
  output logic [RW-1:0]        p2_white,
  output logic [RW-1:0]        round,
  output logic [RW-1:0]        p1_wins,
  output logic [RW-1:0]        p2_wins,
  output logic [1:0]           match_result,
  output logic [1:0]           game_result,
  output logic                 move_err
);

  typedef enum logic [2:0] {
    S_INIT  = 3'b000,
    S_RASP  = 3'b001,
    S_BAWP  = 3'b010,
    S_P1    = 3'b011,
    S_P2    = 3'b100,
    S_MATCH = 3'b101,
    S_GAME  = 3'b110
  } state_t;

  localparam logic [RW-1:0] HALF  = RW'(NUM_CARDS / 2);
  localparam logic [RW-1:0] LASTR = RW'(NUM_CARDS);

  state_t      st;
  logic [4:0]  btn_now;
  logic [4:0]  btn_q;
  logic [4:0]  rise;
  logic        ev_bottom;
  logic        ev_top;
  logic        ev_center;
  logic        ev_left;
  logic        ev_right;
  logic        p1_played;
  logic        p2_played;
  logic        first_p2;
  logic        p1_may;
  logic        p2_may;
  logic        sw_onehot;
  logic [VW-1:0] sw_val;
  logic        p1_ok;
  logic        p2_ok;
  logic        game_done;

  function automatic logic [RW-1:0] pop_par(
    input logic [NUM_CARDS-1:0] c,
    input logic                 odd
  );
    pop_par = '0;
    for (int i = 0; i < NUM_CARDS; i++)
      if (c[i] && ((i % 2) == int'(odd)))
        pop_par = pop_par + 1'b1;
  endfunction

  assign state         = st;
  assign p1_black      = pop_par(p1_cards, 1'b1);
  assign p1_white      = pop_par(p1_cards, 1'b0);
  assign p2_black      = pop_par(p2_cards, 1'b1);
  assign p2_white      = pop_par(p2_cards, 1'b0);
  assign p1_hand_black = p1_played & p1_hand[0];
  assign p2_hand_black = p2_played & p2_hand[0];

  assign btn_now = {bus.btn_bottom, bus.btn_top, bus.btn_center,
                    bus.btn_left, bus.btn_right};
  assign rise    = btn_now & ~btn_q;

  // At most one event per cycle: bottom > top > center > left > right.
  always_comb begin
    ev_bottom = rise[4];
    ev_top    = rise[3] & ~rise[4];
    ev_center = rise[2] & ~|rise[4:3];
    ev_left   = rise[1] & ~|rise[4:2];
    ev_right  = rise[0] & ~|rise[4:1];
  end

  always_comb begin
    sw_val = '0;
    for (int i = 0; i < NUM_CARDS; i++)
      if (bus.sw[i]) sw_val = VW'(i);
  end

  assign sw_onehot = $onehot(bus.sw);
  assign p1_ok     = sw_onehot && ((bus.sw & p1_cards) != '0);
  assign p2_ok     = sw_onehot && ((bus.sw & p2_cards) != '0);
  assign p1_may    = !p1_played && (!first_p2 || p2_played);
  assign p2_may    = !p2_played && (first_p2 || p1_played);
  assign game_done = (p1_wins > HALF) || (p2_wins > HALF) ||
                     (round == LASTR);

`ifdef BAW_TURN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic [VW-1:0] p1_low;
  logic [VW-1:0] p2_low;

  function automatic logic [VW-1:0] low_of(
    input logic [NUM_CARDS-1:0] c
  );
    low_of = '0;
    for (int i = NUM_CARDS - 1; i >= 0; i--)
      if (c[i]) low_of = VW'(i);
  endfunction

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign p1_low  = low_of(p1_cards);
  assign p2_low  = low_of(p2_cards);
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) btn_q <= '0;
    else       btn_q <= btn_now;
  end

  always_ff @(posedge clk) begin
    move_err <= 1'b0;
    if (reset || (ev_bottom && st != S_INIT)) begin
      st           <= S_INIT;
      p1_cards     <= '1;
      p2_cards     <= '1;
      p1_hand      <= '0;
      p2_hand      <= '0;
      p1_played    <= 1'b0;
      p2_played    <= 1'b0;
      first_p2     <= 1'b0;
      round        <= RW'(1);
      p1_wins      <= '0;
      p2_wins      <= '0;
      match_result <= 2'b00;
      game_result  <= 2'b00;
`ifdef BAW_TURN_TIMEOUT_EN
      tmo_cnt      <= '0;
`endif
    end else begin
      unique case (st)
        S_INIT: if (ev_center) st <= S_RASP;
        S_RASP: if (ev_top) st <= S_BAWP;
        S_BAWP: begin
          if (ev_left && p1_may) begin
            st <= S_P1;
`ifdef BAW_TURN_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end else if (ev_right && p2_may) begin
            st <= S_P2;
`ifdef BAW_TURN_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end else if (ev_center && p1_played && p2_played) begin
            st <= S_MATCH;
            if (p1_hand > p2_hand) begin
              match_result <= 2'b01;
              p1_wins      <= p1_wins + 1'b1;
              first_p2     <= 1'b0;
            end else if (p2_hand > p1_hand) begin
              match_result <= 2'b10;
              p2_wins      <= p2_wins + 1'b1;
              first_p2     <= 1'b1;
            end else begin
              match_result <= 2'b11;
            end
          end
        end
        S_P1: begin
          if (ev_top && p1_ok) begin
            p1_cards[sw_val] <= 1'b0;
            p1_hand          <= sw_val;
            p1_played        <= 1'b1;
            st               <= S_BAWP;
          end
`ifdef BAW_TURN_TIMEOUT_EN
          else if (tmo_hit) begin
            p1_cards[p1_low] <= 1'b0;
            p1_hand          <= p1_low;
            p1_played        <= 1'b1;
            st               <= S_BAWP;
          end
`endif
          else if (ev_top) move_err <= 1'b1;
`ifdef BAW_TURN_TIMEOUT_EN
          tmo_cnt <= tmo_cnt + 1'b1;
`endif
        end
        S_P2: begin
          if (ev_top && p2_ok) begin
            p2_cards[sw_val] <= 1'b0;
            p2_hand          <= sw_val;
            p2_played        <= 1'b1;
            st               <= S_BAWP;
          end
`ifdef BAW_TURN_TIMEOUT_EN
          else if (tmo_hit) begin
            p2_cards[p2_low] <= 1'b0;
            p2_hand          <= p2_low;
            p2_played        <= 1'b1;
            st               <= S_BAWP;
          end
`endif
          else if (ev_top) move_err <= 1'b1;
`ifdef BAW_TURN_TIMEOUT_EN
          tmo_cnt <= tmo_cnt + 1'b1;
`endif
        end
        S_MATCH: begin
          if (ev_top) begin
            if (game_done) begin
              st <= S_GAME;
              if (p1_wins > p2_wins)      game_result <= 2'b01;
              else if (p2_wins > p1_wins) game_result <= 2'b10;
              else                        game_result <= 2'b11;
            end else begin
              st           <= S_RASP;
              round        <= round + 1'b1;
              p1_played    <= 1'b0;
              p2_played    <= 1'b0;
              match_result <= 2'b00;
            end
          end
        end
        S_GAME: ;
        default: st <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_baw_game_ctrl.sv
// Directed bench for baw_game_ctrl: turn order, validation, scoring,
// game end, re-init and (when built with it) the turn timeout.
module tb_baw_game_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] state;
  logic [8:0] p1_cards, p2_cards;
  logic [3:0] p1_hand, p2_hand;
  logic       p1_hand_black, p2_hand_black;
  logic [3:0] p1_black, p1_white, p2_black, p2_white;
  logic [3:0] round, p1_wins, p2_wins;
  logic [1:0] match_result, game_result;
  logic       move_err;
  int         vec = 0;
  int         err = 0;

  baw_game_ctrl_if #(.NUM_CARDS(9)) bus ();

  baw_game_ctrl #(.NUM_CARDS(9), .TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .state(state),
    .p1_cards(p1_cards), .p2_cards(p2_cards),
    .p1_hand(p1_hand), .p2_hand(p2_hand),
    .p1_hand_black(p1_hand_black), .p2_hand_black(p2_hand_black),
    .p1_black(p1_black), .p1_white(p1_white),
    .p2_black(p2_black), .p2_white(p2_white),
    .round(round), .p1_wins(p1_wins), .p2_wins(p2_wins),
    .match_result(match_result), .game_result(game_result),
    .move_err(move_err)
  );

  always #5 clk = ~clk;

  localparam int B_CENTER = 0, B_TOP = 1, B_BOTTOM = 2;
  localparam int B_LEFT = 3, B_RIGHT = 4;

  task automatic set_btn(input int b, input logic v);
    case (b)
      B_CENTER: bus.btn_center = v;
      B_TOP:    bus.btn_top    = v;
      B_BOTTOM: bus.btn_bottom = v;
      B_LEFT:   bus.btn_left   = v;
      default:  bus.btn_right  = v;
    endcase
  endtask

  task automatic press(input int b);
    @(negedge clk);
    set_btn(b, 1'b1);
    @(negedge clk);
    set_btn(b, 1'b0);
  endtask

  task automatic play(input bit p2, input int v);
    press(p2 ? B_RIGHT : B_LEFT);
    bus.sw = 9'h001 << v;
    press(B_TOP);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vec++; if (state !== 3'd0) begin err++; $display("FAIL rst_state got %0d want 0", state); end
    vec++; if (p1_cards !== 9'h1FF || p2_cards !== 9'h1FF) begin err++; $display("FAIL rst_cards got %h/%h want 1ff/1ff", p1_cards, p2_cards); end
    vec++; if (round !== 4'd1 || p1_wins !== 4'd0 || p2_wins !== 4'd0) begin err++; $display("FAIL rst_cnt got r%0d w%0d/%0d want r1 w0/0", round, p1_wins, p2_wins); end
    vec++; if (match_result !== 2'b00 || game_result !== 2'b00 || move_err !== 1'b0) begin err++; $display("FAIL rst_res got %b %b %b want 00 00 0", match_result, game_result, move_err); end
  endtask

  task automatic test_setup;
    press(B_CENTER);
    vec++; if (state !== 3'd1) begin err++; $display("FAIL setup_rasp got %0d want 1", state); end
    press(B_TOP);
    vec++; if (state !== 3'd2 || round !== 4'd1) begin err++; $display("FAIL setup_bawp got s%0d r%0d want s2 r1", state, round); end
    vec++; if (p1_black !== 4'd4 || p1_white !== 4'd5 || p1_cards !== 9'h1FF) begin err++; $display("FAIL setup_pop got b%0d w%0d c%h want b4 w5 c1ff", p1_black, p1_white, p1_cards); end
  endtask

  task automatic test_turn_order;
    press(B_RIGHT);
    vec++; if (state !== 3'd2) begin err++; $display("FAIL order_right got %0d want 2", state); end
    play(1'b0, 4);
    vec++; if (p1_hand !== 4'd4 || p1_cards !== 9'h1EF || state !== 3'd2) begin err++; $display("FAIL p1_commit got h%0d c%h s%0d want h4 c1ef s2", p1_hand, p1_cards, state); end
    vec++; if (p1_hand_black !== 1'b0 || p1_white !== 4'd4) begin err++; $display("FAIL p1_colour got k%b w%0d want k0 w4", p1_hand_black, p1_white); end
    press(B_LEFT);
    vec++; if (state !== 3'd2) begin err++; $display("FAIL replay_left got %0d want 2", state); end
    press(B_CENTER);
    vec++; if (state !== 3'd2) begin err++; $display("FAIL early_center got %0d want 2", state); end
    play(1'b1, 2);
    vec++; if (p2_hand !== 4'd2 || p2_cards !== 9'h1FB || state !== 3'd2) begin err++; $display("FAIL p2_commit got h%0d c%h s%0d want h2 c1fb s2", p2_hand, p2_cards, state); end
  endtask

  task automatic test_match;
    press(B_CENTER);
    vec++; if (state !== 3'd5 || match_result !== 2'b01) begin err++; $display("FAIL match got s%0d m%b want s5 m01", state, match_result); end
    vec++; if (p1_wins !== 4'd1 || p2_wins !== 4'd0) begin err++; $display("FAIL wins1 got %0d/%0d want 1/0", p1_wins, p2_wins); end
    @(negedge clk);
    vec++; if (p1_wins !== 4'd1) begin err++; $display("FAIL wins_once got %0d want 1", p1_wins); end
    press(B_TOP);
    vec++; if (state !== 3'd1 || round !== 4'd2 || match_result !== 2'b00) begin err++; $display("FAIL next_round got s%0d r%0d m%b want s1 r2 m00", state, round, match_result); end
  endtask

  task automatic test_move_err;
    press(B_TOP);
    press(B_RIGHT);
    vec++; if (state !== 3'd2) begin err++; $display("FAIL fm_right got %0d want 2", state); end
    play(1'b0, 8);
    vec++; if (p1_cards !== 9'h0EF || p1_hand !== 4'd8) begin err++; $display("FAIL p1_r2 got c%h h%0d want c0ef h8", p1_cards, p1_hand); end
    press(B_RIGHT);
    vec++; if (state !== 3'd4) begin err++; $display("FAIL p2_turn got %0d want 4", state); end
    bus.sw = 9'h003;
    press(B_TOP);
    vec++; if (move_err !== 1'b1 || state !== 3'd4) begin err++; $display("FAIL err_multi got e%b s%0d want e1 s4", move_err, state); end
    @(negedge clk);
    vec++; if (move_err !== 1'b0 || p2_cards !== 9'h1FB) begin err++; $display("FAIL err_pulse got e%b c%h want e0 c1fb", move_err, p2_cards); end
    bus.sw = 9'h004;
    press(B_TOP);
    vec++; if (move_err !== 1'b1 || state !== 3'd4 || p2_hand !== 4'd2) begin err++; $display("FAIL err_played got e%b s%0d h%0d want e1 s4 h2", move_err, state, p2_hand); end
    bus.sw = 9'h001;
    press(B_TOP);
    vec++; if (move_err !== 1'b0 || state !== 3'd2 || p2_cards !== 9'h1FA) begin err++; $display("FAIL p2_r2 got e%b s%0d c%h want e0 s2 c1fa", move_err, state, p2_cards); end
    press(B_CENTER);
    vec++; if (match_result !== 2'b01 || p1_wins !== 4'd2) begin err++; $display("FAIL match2 got m%b w%0d want m01 w2", match_result, p1_wins); end
    press(B_TOP);
  endtask

  task automatic test_p1_game;
    press(B_TOP);
    play(1'b0, 7);
    vec++; if (p1_hand_black !== 1'b1) begin err++; $display("FAIL hand_black got %b want 1", p1_hand_black); end
    play(1'b1, 1);
    press(B_CENTER);
    press(B_TOP);
    press(B_TOP);
    play(1'b0, 6);
    play(1'b1, 3);
    press(B_CENTER);
    vec++; if (p1_wins !== 4'd4 || round !== 4'd4) begin err++; $display("FAIL r4 got w%0d r%0d want w4 r4", p1_wins, round); end
    press(B_TOP);
    vec++; if (state !== 3'd1 || round !== 4'd5) begin err++; $display("FAIL half_not_done got s%0d r%0d want s1 r5", state, round); end
    press(B_TOP);
    play(1'b0, 5);
    play(1'b1, 4);
    press(B_CENTER);
    press(B_TOP);
    vec++; if (state !== 3'd6 || game_result !== 2'b01 || p1_wins !== 4'd5) begin err++; $display("FAIL p1_game got s%0d g%b w%0d want s6 g01 w5", state, game_result, p1_wins); end
    vec++; if (p1_cards !== 9'h00F || p2_cards !== 9'h1E0) begin err++; $display("FAIL end_cards got %h/%h want 00f/1e0", p1_cards, p2_cards); end
    vec++; if (p1_black !== 4'd2 || p2_white !== 4'd2) begin err++; $display("FAIL end_pop got %0d/%0d want 2/2", p1_black, p2_white); end
    press(B_TOP);
    vec++; if (state !== 3'd6) begin err++; $display("FAIL game_hold got %0d want 6", state); end
  endtask

  task automatic test_bottom;
    press(B_BOTTOM);
    vec++; if (state !== 3'd0 || p1_cards !== 9'h1FF || p2_cards !== 9'h1FF) begin err++; $display("FAIL bot_state got s%0d %h/%h want s0 1ff/1ff", state, p1_cards, p2_cards); end
    vec++; if (p1_hand !== 4'd0 || p2_hand !== 4'd0 || round !== 4'd1) begin err++; $display("FAIL bot_hand got %0d/%0d r%0d want 0/0 r1", p1_hand, p2_hand, round); end
    vec++; if (p1_wins !== 4'd0 || match_result !== 2'b00 || game_result !== 2'b00) begin err++; $display("FAIL bot_res got w%0d m%b g%b want w0 m00 g00", p1_wins, match_result, game_result); end
  endtask

  task automatic test_draws;
    press(B_CENTER);
    for (int r = 1; r <= 9; r++) begin
      press(B_TOP);
      play(1'b0, r - 1);
      play(1'b1, r - 1);
      press(B_CENTER);
      vec++; if (match_result !== 2'b11 || p1_wins !== 4'd0 || p2_wins !== 4'd0 || round !== 4'(r)) begin err++; $display("FAIL draw%0d got m%b w%0d/%0d r%0d want m11 w0/0", r, match_result, p1_wins, p2_wins, round); end
      press(B_TOP);
    end
    vec++; if (state !== 3'd6 || game_result !== 2'b11 || p1_cards !== 9'h000) begin err++; $display("FAIL draw_game got s%0d g%b c%h want s6 g11 c000", state, game_result, p1_cards); end
  endtask

  task automatic test_timeout;
    press(B_BOTTOM);
    press(B_CENTER);
    press(B_TOP);
    press(B_LEFT);
    vec++; if (state !== 3'd3) begin err++; $display("FAIL tmo_enter got %0d want 3", state); end
`ifdef BAW_TURN_TIMEOUT_EN
    repeat (10) @(negedge clk);
    vec++; if (state !== 3'd2 || p1_hand !== 4'd0 || p1_cards !== 9'h1FE || move_err !== 1'b0) begin err++; $display("FAIL tmo_commit got s%0d h%0d c%h e%b want s2 h0 c1fe e0", state, p1_hand, p1_cards, move_err); end
`else
    repeat (12) @(negedge clk);
    vec++; if (state !== 3'd3 || p1_cards !== 9'h1FF) begin err++; $display("FAIL no_tmo got s%0d c%h want s3 c1ff", state, p1_cards); end
`endif
  endtask

  initial begin
    reset = 1'b1;
    bus.btn_center = 1'b0;
    bus.btn_top    = 1'b0;
    bus.btn_bottom = 1'b0;
    bus.btn_left   = 1'b0;
    bus.btn_right  = 1'b0;
    bus.sw         = '0;
    test_reset;
    test_setup;
    test_turn_order;
    test_match;
    test_move_err;
    test_p1_game;
    test_bottom;
    test_draws;
    test_timeout;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
